// File: rtl/load_store_unit.sv
// rv32i load/store unit: runs one valid/ready data-memory transaction per access,
// aligns and extends load data, and selects the register-file writeback value.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LSB   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [2:0]            fun3,
    input  logic                  Load,
    input  logic                  Store,
    input  logic                  mem_en,
    input  logic [1:0]            mem_to_reg,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [DATA_WIDTH-1:0] req_addr,
    output logic                  req_we,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [3:0]            req_wmask,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  stall,
    output logic                  access_fault,
    output logic [DATA_WIDTH-1:0] rwd_data_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                state, next_state;
    logic                  start, misaligned, illegal, fault, start_ok, load_fault;
    logic [ADDR_LSB-1:0]   addr_lo;
    logic [2:0]            fun3_q;
    logic [DATA_WIDTH-1:0] load_data, load_ext, lane_wdata;
    logic [3:0]            lane_mask;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    always_comb begin
        start = mem_en & (Load | Store) & (state == IDLE);
        case (fun3[1:0])
            2'b01:   misaligned = alu_result[0];
            2'b10:   misaligned = |alu_result[1:0];
            default: misaligned = 1'b0;
        endcase
        illegal = (Load & (fun3 == 3'b011 || fun3 == 3'b110 || fun3 == 3'b111)) |
                  (Store & !(fun3 == 3'b000 || fun3 == 3'b001 || fun3 == 3'b010));
        fault      = misaligned | illegal;
        start_ok   = start & ~fault;
        load_fault = start & fault & Load;
    end

    // Store lanes are replicated so the memory only needs the byte enables.
    always_comb begin
        case (fun3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << alu_result[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_mask  = alu_result[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        byte_sel = rsp_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        case (fun3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = rsp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_ok) next_state = REQ;
            REQ:  if (req_ready) next_state = req_we ? DONE : WAIT;
            WAIT: if (rsp_valid) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_valid    = (state == REQ);
        stall        = start_ok | (state == REQ) | (state == WAIT);
        access_fault = start & fault;
    end

    // Request fields are latched at start so upstream may move on while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            req_wmask <= 4'b0000;
            addr_lo   <= '0;
            fun3_q    <= 3'b000;
            load_data <= '0;
        end else begin
            if (start_ok) begin
                req_addr  <= {alu_result[DATA_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
                req_we    <= Store;
                req_wdata <= Store ? lane_wdata : '0;
                req_wmask <= Store ? lane_mask : 4'b0000;
                addr_lo   <= alu_result[ADDR_LSB-1:0];
                fun3_q    <= fun3;
            end
            if (load_fault)
                load_data <= '0;
            else if (state == WAIT && rsp_valid)
                load_data <= load_ext;
        end
    end

    always_comb begin
        if (load_fault) begin
            rwd_data_out = '0;
        end else begin
            case (mem_to_reg)
                2'b00:   rwd_data_out = alu_result;
                2'b01:   rwd_data_out = load_data;
                2'b10:   rwd_data_out = pc + DATA_WIDTH'(4);
                default: rwd_data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected requests and writeback values are
// queued when a transaction is driven and compared when the unit produces them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result = '0, store_data = '0, pc = '0;
    logic [2:0]  fun3 = '0;
    logic        Load = 1'b0, Store = 1'b0, mem_en = 1'b0;
    logic [1:0]  mem_to_reg = '0;
    logic        req_valid, req_we, stall, access_fault;
    logic        req_ready = 1'b0, rsp_valid = 1'b0;
    logic [31:0] req_addr, req_wdata, rwd_data_out;
    logic [31:0] rsp_rdata = '0;
    logic [3:0]  req_wmask;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rwd_q[$];
    int          total = 0;
    int          passed = 0;
    int          stall_cycles, req_count;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_LSB(2)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .store_data(store_data), .pc(pc),
        .fun3(fun3), .Load(Load), .Store(Store), .mem_en(mem_en), .mem_to_reg(mem_to_reg),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .stall(stall), .access_fault(access_fault),
        .rwd_data_out(rwd_data_out)
    );

    // Drives one access and plays the memory; noise drives junk responses before WAIT.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [1:0] m2r, input logic [31:0] rdata,
                           input int ready_delay, input int rsp_delay, input logic noise);
        int   phase = 0, req_cycles = 0, wait_cycles = 0;
        logic done = 1'b0, have_first = 1'b0;
        req_t first, exp;
        logic [31:0] exp_rwd;
        stall_cycles = 0;
        req_count = 0;
        @(negedge clk);
        mem_en = 1'b1; Load = ld; Store = st; fun3 = f3;
        alu_result = addr; store_data = sdata; mem_to_reg = m2r;
        for (int k = 0; k < 60 && !done; k++) begin
            if (k == 1) begin
                mem_en = 1'b0; Load = 1'b0; Store = 1'b0; fun3 = 3'b111; store_data = '0;
            end
            if (phase == 0) begin
                req_ready = (req_cycles >= ready_delay);
                rsp_valid = noise;
                rsp_rdata = noise ? 32'hBAD0BAD0 : rdata;
            end else begin
                rsp_valid = (wait_cycles >= rsp_delay);
                rsp_rdata = rdata;
            end
            #1;
            if (stall) stall_cycles++;
            if (k > 0 && !stall) begin
                done = 1'b1;
                total++;
                if (exp_rwd_q.size() == 0) begin
                    $display("[TB] FAIL rwd_scoreboard: got %h with no expected entry", rwd_data_out);
                end else begin
                    exp_rwd = exp_rwd_q.pop_front();
                    if (rwd_data_out !== exp_rwd)
                        $display("[TB] FAIL rwd_data_out: got %h expected %h", rwd_data_out, exp_rwd);
                    else passed++;
                end
            end else if (req_valid) begin
                if (!have_first) begin
                    first = '{req_addr, req_we, req_wdata, req_wmask};
                    have_first = 1'b1;
                end else begin
                    total++;
                    if ({req_addr, req_we, req_wdata, req_wmask} !== first)
                        $display("[TB] FAIL req_stable: got %h expected %h",
                                 {req_addr, req_we, req_wdata, req_wmask}, first);
                    else passed++;
                end
                req_cycles++;
                if (req_ready) begin
                    req_count++;
                    phase = 1;
                    total++;
                    if (exp_req_q.size() == 0) begin
                        $display("[TB] FAIL req_scoreboard: got addr %h with no expected entry", req_addr);
                    end else begin
                        exp = exp_req_q.pop_front();
                        if ({req_addr, req_we, req_wdata, req_wmask} !== exp)
                            $display("[TB] FAIL request: got addr %h we %b wdata %h mask %b expected addr %h we %b wdata %h mask %b",
                                     req_addr, req_we, req_wdata, req_wmask,
                                     exp.addr, exp.we, exp.wdata, exp.mask);
                        else passed++;
                    end
                end
            end else if (phase == 1) begin
                wait_cycles++;
            end
            if (!done) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            $display("[TB] FAIL timeout: got no retire within 60 cycles, expected DONE");
        end
        @(posedge clk);
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || req_valid !== 1'b0)
            $display("[TB] FAIL after_done: got stall %b req_valid %b expected 0 0", stall, req_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_to_reg = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({req_valid, req_we, access_fault, stall} !== 4'b0000)
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {req_valid, req_we, access_fault, stall});
        else passed++;
        total++;
        if ({req_addr, req_wdata, req_wmask, rwd_data_out} !== '0)
            $display("[TB] FAIL reset_data: got addr %h wdata %h mask %b rwd %h expected all 0",
                     req_addr, req_wdata, req_wmask, rwd_data_out);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic check_txn_shape(input string name, input int exp_stall);
        total++;
        if (stall_cycles !== exp_stall || req_count !== 1)
            $display("[TB] FAIL %s_shape: got stall %0d requests %0d expected stall %0d requests 1",
                     name, stall_cycles, req_count, exp_stall);
        else passed++;
    endtask

    task automatic test_stores();
        exp_req_q.push_back('{32'h100, 1'b1, 32'hDEADBEEF, 4'b1111});
        exp_rwd_q.push_back(32'h100);
        run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2'b00, '0, 0, 0, 1'b0);
        check_txn_shape("sw", 2);
        exp_req_q.push_back('{32'h100, 1'b1, 32'hA5A5A5A5, 4'b1000});
        exp_rwd_q.push_back(32'h103);
        run_txn(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 2'b00, '0, 0, 0, 1'b0);
        check_txn_shape("sb3", 2);
        exp_req_q.push_back('{32'h100, 1'b1, 32'h5A5A5A5A, 4'b0010});
        exp_rwd_q.push_back(32'h101);
        run_txn(1'b0, 1'b1, 3'b000, 32'h101, 32'h1234565A, 2'b00, '0, 0, 0, 1'b0);
        check_txn_shape("sb1", 2);
        exp_req_q.push_back('{32'h100, 1'b1, 32'h12341234, 4'b1100});
        exp_rwd_q.push_back(32'h102);
        run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 2'b00, '0, 0, 0, 1'b0);
        check_txn_shape("sh2", 2);
        exp_req_q.push_back('{32'h100, 1'b1, 32'h56785678, 4'b0011});
        exp_rwd_q.push_back(32'h100);
        run_txn(1'b0, 1'b1, 3'b001, 32'h100, 32'hFFFF5678, 2'b00, '0, 0, 0, 1'b0);
        check_txn_shape("sh0", 2);
    endtask

    task automatic test_loads();
        logic [2:0]  f3s[5]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] addrs[5] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h200};
        logic [31:0] exps[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        for (int i = 0; i < 5; i++) begin
            exp_req_q.push_back('{32'h200, 1'b0, 32'h0, 4'b0000});
            exp_rwd_q.push_back(exps[i]);
            run_txn(1'b1, 1'b0, f3s[i], addrs[i], 32'hFFFFFFFF, 2'b01, 32'h80FF7F01, 0, 0, 1'b0);
            check_txn_shape("load", 3);
        end
    endtask

    task automatic test_fault();
        logic [2:0]  f3s[3]   = '{3'b010, 3'b001, 3'b011};
        logic [31:0] addrs[3] = '{32'h102, 32'h101, 32'h100};
        logic        lds[3]   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_en = 1'b1; Load = lds[i]; Store = ~lds[i]; fun3 = f3s[i];
            alu_result = addrs[i]; mem_to_reg = lds[i] ? 2'b01 : 2'b11;
            req_ready = 1'b1;
            #1;
            total++;
            if ({access_fault, req_valid, stall, rwd_data_out} !== {3'b100, 32'h0})
                $display("[TB] FAIL fault_pulse%0d: got fault %b valid %b stall %b rwd %h expected 1 0 0 0",
                         i, access_fault, req_valid, stall, rwd_data_out);
            else passed++;
            @(posedge clk);
            @(negedge clk);
            mem_en = 1'b0; Load = 1'b0; Store = 1'b0; mem_to_reg = 2'b01;
            #1;
            total++;
            if ({access_fault, req_valid, stall, rwd_data_out} !== {3'b000, 32'h0})
                $display("[TB] FAIL fault_after%0d: got fault %b valid %b stall %b rwd %h expected 0 0 0 0",
                         i, access_fault, req_valid, stall, rwd_data_out);
            else passed++;
        end
        req_ready = 1'b0;
    endtask

    task automatic test_back_to_back_stretched();
        exp_req_q.push_back('{32'h300, 1'b0, 32'h0, 4'b0000});
        exp_rwd_q.push_back(32'hCAFEF00D);
        run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 2'b01, 32'hCAFEF00D, 5, 3, 1'b1);
        check_txn_shape("stretched", 11);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        mem_en = 1'b1; Load = 1'b1; Store = 1'b0; fun3 = 3'b010;
        alu_result = 32'h400; mem_to_reg = 2'b01; req_ready = 1'b1; rsp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mem_en = 1'b0; Load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        total++;
        if ({stall, req_valid} !== 2'b10)
            $display("[TB] FAIL wait_state: got stall %b valid %b expected 1 0", stall, req_valid);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({req_valid, req_we, access_fault, stall, req_wmask} !== 8'h00 ||
            {req_addr, req_wdata, rwd_data_out} !== '0)
            $display("[TB] FAIL reset_in_wait: got valid %b we %b stall %b addr %h wdata %h mask %b rwd %h expected all 0",
                     req_valid, req_we, stall, req_addr, req_wdata, req_wmask, rwd_data_out);
        else passed++;
        rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        total++;
        if ({stall, req_valid, rwd_data_out} !== {2'b00, 32'h0})
            $display("[TB] FAIL late_rsp: got stall %b valid %b rwd %h expected 0 0 0", stall, req_valid, rwd_data_out);
        else passed++;
    endtask

    task automatic test_writeback_select();
        logic [1:0]  sels[4] = '{2'b10, 2'b10, 2'b00, 2'b11};
        logic [31:0] pcs[4]  = '{32'hFFFFFFFC, 32'h00001000, 32'h0, 32'h0};
        logic [31:0] exps[4] = '{32'h00000000, 32'h00001004, 32'h13572468, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_en = 1'b0; mem_to_reg = sels[i]; pc = pcs[i]; alu_result = 32'h13572468;
            #1;
            total++;
            if (rwd_data_out !== exps[i])
                $display("[TB] FAIL wb_sel%0d: got %h expected %h", i, rwd_data_out, exps[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_fault();
        test_back_to_back_stretched();
        test_reset_in_wait();
        test_writeback_select();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
